// File: rtl/multi_pipe_generator.sv
`default_nettype none
// ============================================================================
// Module   : multi_pipe_generator
// Purpose  : Scrolling pipe obstacles with LFSR gap heights and pass pulses.
// Revision : 1.0  initial release
// ============================================================================
module multi_pipe_generator #(
  parameter int          NUM_PIPES    = 3,
  parameter int          X_W          = 11,
  parameter int          SCREEN_W     = 1023,
  parameter int          PIPE_SPACING = 400,
  parameter int          STEP         = 3,
  parameter int          Y_MIN        = 300,
  parameter int          Y_MAX        = 560,
  parameter int          Y_INIT       = 320,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     RESET_GAME_N,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     move,
  input  logic [X_W-1:0]           bird_x,
  output logic [NUM_PIPES*X_W-1:0] pipe_x,
  output logic [NUM_PIPES*X_W-1:0] pipe_y,
  output logic [NUM_PIPES-1:0]     pipe_valid,
  output logic                     pass_pulse,
  output logic                     running
);

  localparam int c_wrap    = NUM_PIPES * PIPE_SPACING;
  localparam int c_y_range = Y_MAX - Y_MIN;
  localparam int c_yb      = $clog2(c_y_range + 1);
  localparam int c_cnt_w   = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

  if (c_wrap < SCREEN_W + 1) begin : g_chk_wrap
    $error("NUM_PIPES*PIPE_SPACING must cover the screen width");
  end
  if (PIPE_SPACING <= STEP) begin : g_chk_step
    $error("PIPE_SPACING must exceed STEP");
  end
  if (SCREEN_W + 1 + (NUM_PIPES - 1) * PIPE_SPACING >= (1 << X_W)) begin : g_chk_xw
    $error("initial pipe x does not fit in X_W bits");
  end
  if (Y_MAX >= (1 << X_W)) begin : g_chk_yw
    $error("Y_MAX does not fit in X_W bits");
  end
  if (LFSR_SEED == 16'h0000) begin : g_chk_seed
    $error("LFSR_SEED must be nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_RUN    = 2'd2,
    S_FROZEN = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_cnt_w-1:0]   r_load_cnt;
  logic [15:0]          r_lfsr;
  logic                 r_pass;
  logic [c_yb-1:0]      w_r;
  logic [c_yb-1:0]      w_off;
  logic [X_W-1:0]       w_y_rand;
  logic [NUM_PIPES-1:0] w_pass;
  logic                 w_load_last;
  logic                 w_load_enter;
  logic                 w_tick;

  assign w_load_last  = (r_load_cnt == c_cnt_w'(NUM_PIPES - 1));
  assign w_load_enter = ((r_state == S_IDLE) || (r_state == S_FROZEN)) && start;
  // stop has priority over move, so a tick only happens when stop is low
  assign w_tick       = (r_state == S_RUN) && move && !stop;

  always_ff @(posedge clk or negedge RESET_GAME_N) begin
    if (!RESET_GAME_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start)       w_state_next = S_LOAD;
      S_LOAD:   if (w_load_last) w_state_next = S_RUN;
      S_RUN:    if (stop)        w_state_next = S_FROZEN;
      S_FROZEN: if (start)       w_state_next = S_LOAD;
      default:                   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_GAME_N) begin
    if (!RESET_GAME_N) begin
      r_load_cnt <= '0;
    end else if (w_load_enter) begin
      r_load_cnt <= '0;
    end else if ((r_state == S_LOAD) && !w_load_last) begin
      r_load_cnt <= r_load_cnt + c_cnt_w'(1);
    end
  end

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
  always_ff @(posedge clk or negedge RESET_GAME_N) begin
    if (!RESET_GAME_N) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    end
  end

  // Out-of-range raw values fold back by R+1 instead of clamping, keeping spread
  assign w_r = r_lfsr[c_yb-1:0];
  always_comb begin
    w_off = w_r;
    if (int'(w_r) > c_y_range) begin
      w_off = w_r - c_yb'(c_y_range + 1);
    end
  end
  assign w_y_rand = X_W'(Y_MIN) + X_W'(w_off);

  for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
    localparam logic [X_W-1:0] c_x_init = X_W'(SCREEN_W + 1 + gi * PIPE_SPACING);

    logic [X_W-1:0] r_x;
    logic [X_W-1:0] r_y;
    logic           w_wrap;
    logic [X_W-1:0] w_x_step;

    assign w_wrap   = (r_x < X_W'(STEP));
    assign w_x_step = w_wrap ? (r_x + X_W'(c_wrap - STEP)) : (r_x - X_W'(STEP));
    assign w_pass[gi] = !w_wrap && (r_x >= bird_x) && (w_x_step < bird_x);

    always_ff @(posedge clk or negedge RESET_GAME_N) begin
      if (!RESET_GAME_N) begin
        r_x <= c_x_init;
        r_y <= X_W'(Y_INIT);
      end else begin
        if (w_load_enter) begin
          r_x <= c_x_init;
        end else if (w_tick) begin
          r_x <= w_x_step;
        end
        if (((r_state == S_LOAD) && (r_load_cnt == c_cnt_w'(gi))) || (w_tick && w_wrap)) begin
          r_y <= w_y_rand;
        end
      end
    end

    assign pipe_x[gi*X_W +: X_W] = r_x;
    assign pipe_y[gi*X_W +: X_W] = r_y;
    assign pipe_valid[gi]        = (r_x <= X_W'(SCREEN_W));
  end

  always_ff @(posedge clk or negedge RESET_GAME_N) begin
    if (!RESET_GAME_N) begin
      r_pass <= 1'b0;
    end else begin
      r_pass <= w_tick && (|w_pass);
    end
  end

  assign pass_pulse = r_pass;
  assign running    = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_multi_pipe_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_pipe_generator
// Purpose  : Directed + random checks of multi_pipe_generator against a game model.
// Revision : 1.0  initial release
// ============================================================================
module tb_multi_pipe_generator;

  logic        clk = 1'b0;
  logic        RESET_GAME_N;
  logic        start, stop, move;
  logic [10:0] bird_x;
  logic [32:0] pipe_x, pipe_y;
  logic [2:0]  pipe_valid;
  logic        pass_pulse, running;

  int total = 0;
  int bad   = 0;

  // game model: mode 0 idle, 1 loading, 2 running, 3 frozen
  int       m_mode, m_k;
  int       m_x[3], m_y[3];
  bit [15:0] m_lfsr;
  bit       m_pass;
  int       first_y[3];

  multi_pipe_generator dut (
    .clk(clk), .RESET_GAME_N(RESET_GAME_N), .start(start), .stop(stop), .move(move),
    .bird_x(bird_x), .pipe_x(pipe_x), .pipe_y(pipe_y), .pipe_valid(pipe_valid),
    .pass_pulse(pass_pulse), .running(running)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rand_y(input bit [15:0] l);
    int r;
    r = int'(l) % 512;
    if (r > 260) r = r - 261;
    return 300 + r;
  endfunction

  function automatic bit [15:0] lfsr_next(input bit [15:0] l);
    bit fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return (l >> 1) | (16'(fb) << 15);
  endfunction

  function automatic logic [32:0] pack3(input int a0, input int a1, input int a2);
    logic [32:0] p;
    p[10:0]  = 11'(a0);
    p[21:11] = 11'(a1);
    p[32:22] = 11'(a2);
    return p;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_pass = 0; m_lfsr = 16'hACE1;
    for (int i = 0; i < 3; i++) begin
      m_x[i] = 1024 + 400 * i;
      m_y[i] = 320;
    end
  endtask

  task automatic model_edge(input bit st, input bit sp, input bit mv);
    int yr, nx;
    yr = rand_y(m_lfsr);
    m_pass = 0;
    case (m_mode)
      0, 3: if (st) begin
        m_mode = 1; m_k = 0;
        for (int i = 0; i < 3; i++) m_x[i] = 1024 + 400 * i;
      end
      1: begin
        m_y[m_k] = yr;
        if (m_k == 2) m_mode = 2; else m_k++;
      end
      default: if (sp) m_mode = 3;
               else if (mv) begin
                 for (int i = 0; i < 3; i++) begin
                   if (m_x[i] >= 3) begin
                     nx = m_x[i] - 3;
                     if (m_x[i] >= int'(bird_x) && nx < int'(bird_x)) m_pass = 1;
                     m_x[i] = nx;
                   end else begin
                     m_x[i] = m_x[i] + 1200 - 3;
                     m_y[i] = yr;
                   end
                 end
               end
    endcase
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic check_all();
    chk("pipe_x", pipe_x, pack3(m_x[0], m_x[1], m_x[2]));
    chk("pipe_y", pipe_y, pack3(m_y[0], m_y[1], m_y[2]));
    chk("pipe_valid", pipe_valid, {m_x[2] <= 1023, m_x[1] <= 1023, m_x[0] <= 1023});
    chk("running", running, m_mode == 2);
    chk("pass_pulse", pass_pulse, m_pass);
  endtask

  task automatic tick(input bit st, input bit sp, input bit mv);
    start = st; stop = sp; move = mv;
    @(posedge clk);
    model_edge(st, sp, mv);
    #1;
    check_all();
    start = 0; stop = 0; move = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_x"}, pipe_x, {11'd1824, 11'd1424, 11'd1024});
    chk({tag, "_y"}, pipe_y, {11'd320, 11'd320, 11'd320});
    chk({tag, "_valid"}, pipe_valid, 3'b000);
    chk({tag, "_running"}, running, 1'b0);
    chk({tag, "_pass"}, pass_pulse, 1'b0);
  endtask

  initial begin
    logic [32:0] saved_x;
    int old1, old2, nx0, bird;

    RESET_GAME_N = 1'b0; start = 0; stop = 0; move = 0; bird_x = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    RESET_GAME_N = 1'b1;

    // moves in IDLE are ignored
    repeat (10) tick(0, 0, 1);
    chk("idle_x_hold", pipe_x, {11'd1824, 11'd1424, 11'd1024});

    // load sequence
    tick(1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 0);
      chk("load_y_range", (pipe_y[k*11 +: 11] >= 300) && (pipe_y[k*11 +: 11] <= 560), 1'b1);
      chk("load_running", running, k == 2);
      first_y[k] = int'(pipe_y[k*11 +: 11]);
    end

    tick(0, 0, 1);
    chk("first_move_x0", pipe_x[10:0], 11'd1021);
    chk("first_move_valid0", pipe_valid[0], 1'b1);

    // advance pipe0 to x=1, then wrap
    for (int n = 0; n < 400 && m_x[0] != 1; n++) tick(0, 0, 1);
    chk("pre_wrap_x0", pipe_x[10:0], 11'd1);
    old1 = int'(pipe_x[21:11]);
    old2 = int'(pipe_x[32:22]);
    tick(0, 0, 1);
    chk("wrap_x0", pipe_x[10:0], 11'd1198);
    chk("wrap_y0_range", (pipe_y[10:0] >= 300) && (pipe_y[10:0] <= 560), 1'b1);
    chk("wrap_x1", pipe_x[21:11], 11'(old1 - 3));
    chk("wrap_x2", pipe_x[32:22], 11'(old2 - 3));
    nx0 = int'(pipe_x[10:0]);
    chk("wrap_spacing", nx0 - int'(pipe_x[32:22]), 400);

    // pass detection on pipe1
    bird_x = 11'(m_x[1] - 1);
    tick(0, 0, 1);
    chk("pass_hit", pass_pulse, 1'b1);
    tick(0, 0, 0);
    chk("pass_one_clk", pass_pulse, 1'b0);
    tick(0, 0, 1);
    chk("pass_no_repeat", pass_pulse, 1'b0);
    bird_x = '0;

    // stop beats move, then start beats stop
    saved_x = pipe_x;
    tick(0, 1, 1);
    chk("stop_hold_x", pipe_x, saved_x);
    chk("stop_running", running, 1'b0);
    chk("stop_no_pass", pass_pulse, 1'b0);
    tick(1, 1, 0);
    chk("restart_x", pipe_x, {11'd1824, 11'd1424, 11'd1024});
    repeat (3) tick(0, 0, 0);
    chk("restart_running", running, 1'b1);

    // randomized play
    bird = 400;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 49) == 0) bird = int'($urandom_range(50, 1000));
      bird_x = 11'(bird);
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1);
    end

    // ensure RUN, then asynchronous reset between edges
    bird_x = '0;
    tick(1, 0, 0);
    repeat (4) tick(0, 0, 0);
    tick(0, 0, 1);
    tick(0, 0, 1);
    chk("pre_reset_running", running, 1'b1);
    @(negedge clk);
    RESET_GAME_N = 1'b0;
    #1;
    model_reset();
    check_reset_values("async_reset");
    @(posedge clk);
    #1;
    check_reset_values("reset_held");
    @(negedge clk);
    RESET_GAME_N = 1'b1;

    repeat (10) tick(0, 0, 1);
    tick(1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 0);
      chk("y_sequence_repeat", pipe_y[k*11 +: 11], 11'(first_y[k]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_pipe_generator.md
Name: multi_pipe_generator

Overview:
- Generates NUM_PIPES scrolling pipe obstacles for the game. Each pipe has its own x position and its own gap-centre y.
- All pipes advance on a single-cycle `move` tick. Each pipe wraps back off-screen with a fresh pseudo-random gap while the fixed spacing between pipes is preserved.
- Sits between the frame-tick generator and the renderer / collision checker.
- Also reports when the bird clears a pipe, for scoring.

Parameters:
- NUM_PIPES, 3: number of pipes in flight.
- X_W, 11: width of every x/y coordinate.
- SCREEN_W, 1023: last visible x column.
- PIPE_SPACING, 400: x distance between consecutive pipes.
- STEP, 3: pixels moved per `move` tick.
- Y_MIN, 300: minimum gap y.
- Y_MAX, 560: maximum gap y.
- Y_INIT, 320: gap y before the first load.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock; all state is clocked on the rising edge.
- RESET_GAME_N  in  1  asynchronous, active-low reset.
- start  in  1  begin or restart a run; sampled each clk.
- stop  in  1  freeze the pipes (collision); sampled each clk.
- move  in  1  one-cycle frame tick; a synchronous enable, never used as a clock.
- bird_x  in  X_W  bird's x column, used for pass detection.
- pipe_x  out  NUM_PIPES*X_W  packed x positions; pipe i at bits [i*X_W +: X_W].
- pipe_y  out  NUM_PIPES*X_W  packed gap y values, same packing as pipe_x.
- pipe_valid  out  NUM_PIPES  bit i = (pipe_x[i] <= SCREEN_W).
- pass_pulse  out  1  one-cycle pulse when any pipe crosses bird_x.
- running  out  1  high in RUN.

Behaviour:
- Reset (RESET_GAME_N low, asynchronous; outputs change immediately, not at the next edge):
  - state = IDLE.
  - pipe_x[i] = SCREEN_W+1+i*PIPE_SPACING.
  - pipe_y[i] = Y_INIT.
  - LFSR = LFSR_SEED.
  - load counter = 0.
  - pass_pulse = 0, running = 0.
  - pipe_valid is all zeros as a consequence of the x values.
- Static constraints, enforced by an elaboration/simulation check:
  - WRAP = NUM_PIPES*PIPE_SPACING >= SCREEN_W+1.
  - PIPE_SPACING > STEP.
  - SCREEN_W+1+(NUM_PIPES-1)*PIPE_SPACING < 2^X_W.
  - Y_MAX < 2^X_W.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every clk in every state.
- Random y:
  - R = Y_MAX-Y_MIN; YB = clog2(R+1); r = LFSR[YB-1:0].
  - y_rand = Y_MIN + (r > R ? r-(R+1) : r).
  - Combinational from the current LFSR value; always in [Y_MIN, Y_MAX].
- State machine:
  - IDLE: start -> LOAD. move and stop are ignored.
  - LOAD, NUM_PIPES cycles: on entry, pipe_x[i] = SCREEN_W+1+i*PIPE_SPACING. In load cycle k, pipe_y[k] = y_rand. After cycle NUM_PIPES-1 -> RUN. move, start and stop are ignored.
  - RUN: running = 1. stop -> FROZEN. Otherwise, on move, every pipe updates in the same cycle (see Per-pipe update). start is ignored.
  - FROZEN: positions and y values hold. pass_pulse = 0. start -> LOAD.
- Per-pipe update on move in RUN:
  - If x >= STEP: x <= x-STEP.
  - Else (wrap): x <= x+WRAP-STEP and y <= y_rand. This keeps inter-pipe spacing exact.
  - At most one pipe wraps per tick, guaranteed by the spacing constraint.
- Pass detection:
  - Pipe i passes when it does not wrap, x_old >= bird_x and x_new < bird_x.
  - pass_pulse is registered: high exactly one clk, on the cycle after the move edge.
  - If several pipes cross on the same tick, a single pulse is produced.
- Simultaneous events and mid-operation cases:
  - stop and move in the same cycle in RUN: stop wins; no movement, no pass_pulse.
  - start and stop in the same cycle in FROZEN: start wins -> LOAD.
  - Reset mid-LOAD or mid-RUN: immediate return to the reset values.
- pipe_valid is combinational from the pipe_x registers.

Test Plan:
- Reset, defaults:
  - Required: pipe_x = {1824,1424,1024}, pipe_y all 320, pipe_valid = 3'b000, running = 0.
  - Then 10 move ticks in IDLE: no change.
- start pulse:
  - Required: LOAD for 3 clks with pipe_y[k] written at load cycle k, each value in [300,560].
  - running = 1 at the 4th clk after start.
  - Then one move: pipe0 1024 -> 1021; pipe_valid[0] goes 1 on the next tick.
- Wrap:
  - Drive pipe0 to x = 2, then move.
  - Required: pipe0 x = 1199 and a new y in [300,560]; pipe1 and pipe2 x each decrease by 3; spacing to its neighbours preserved.
- Pass:
  - bird_x = 200, pipe0 x = 201, then move.
  - Required: x = 198 and pass_pulse high exactly 1 clk.
  - Next move (x = 195): no pulse.
- stop and move asserted together in RUN:
  - Required: positions unchanged, FROZEN, running = 0.
  - Later start: LOAD re-initialises x to {1824,1424,1024}.
- RESET_GAME_N low mid-RUN, between clk edges:
  - Required: outputs return to reset values without waiting for a clk edge.
  - LFSR restarts at 16'hACE1, so the y sequence after the next start repeats the first run's.
